// File: rtl/kv10_mem_pkg.sv
// Shared types and widths for the KV10 memory path.
package kv10_mem_pkg;

  localparam int unsigned PADDR_W = 22;
  localparam int unsigned WORD_W  = 36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Busy-cycle counter for mem_arb; flags when a mem transaction has run TIMEOUT cycles.
// Exists only in builds with MEM_ARB_TIMEOUT_EN defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear while idle, count busy cycles, saturate at the terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule
`endif

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing the single mem port between port A (PAG) and port B (DMA).
// Optional bus-error timeout on a silent mem is enabled with MEM_ARB_TIMEOUT_EN.
module mem_arb
  import kv10_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = PADDR_W,
  parameter int unsigned DATA_W  = WORD_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_write_data,
  output logic [DATA_W-1:0] a_read_data,
  output logic              a_read_ack,
  output logic              a_write_ack,
  output logic              a_nxm,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_write_data,
  output logic [DATA_W-1:0] b_read_data,
  output logic              b_read_ack,
  output logic              b_write_ack,
  output logic              b_nxm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_read_ack,
  input  logic              mem_write_ack
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_arb: TIMEOUT must be at least 2");
  end

  arb_state_t state_q;
  arb_state_t state_d;
  arb_port_t  last_q;
  arb_port_t  last_d;

  logic              a_req;
  logic              b_req;
  logic              sel_b;
  logic              x_read;
  logic              x_write;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata;
  logic              mem_ack;
  logic              expired;
  logic              x_read_ack;
  logic              x_write_ack;
  logic              x_nxm;
  logic [DATA_W-1:0] x_read_data;

  // Request summary and the currently granted port's request lines.
  always_comb begin
    a_req   = a_read | a_write;
    b_req   = b_read | b_write;
    sel_b   = (state_q == BUSY_B);
    mem_ack = mem_read_ack | mem_write_ack;
    x_read  = sel_b ? b_read       : a_read;
    x_write = sel_b ? b_write      : a_write;
    x_addr  = sel_b ? b_addr       : a_addr;
    x_wdata = sel_b ? b_write_data : a_write_data;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic busy;
  logic cnt_expired;

  assign busy = (state_q != IDLE);

  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (~busy),
    .inc     (busy),
    .expired (cnt_expired)
  );

  assign expired = busy & cnt_expired;
`else
  assign expired = 1'b0;
`endif

  // Grant decision, mem strobes and completion for the granted port.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    x_read_ack     = 1'b0;
    x_write_ack    = 1'b0;
    x_nxm          = 1'b0;
    x_read_data    = '0;
    unique case (state_q)
      IDLE: begin
        if (a_req && (!b_req || (last_q == PORT_B))) begin
          state_d = BUSY_A;
        end else if (b_req) begin
          state_d = BUSY_B;
        end
      end
      BUSY_A, BUSY_B: begin
        mem_addr       = x_addr;
        mem_write_data = x_wdata;
        if (mem_ack) begin
          mem_read    = x_read;
          mem_write   = x_write & ~x_read;
          x_read_ack  = mem_read_ack;
          x_write_ack = mem_write_ack;
          x_read_data = mem_read_ack ? mem_read_data : '0;
          state_d     = IDLE;
          last_d      = sel_b ? PORT_B : PORT_A;
        end else if (expired) begin
          // Silent mem: drop strobes and complete with a bus error.
          x_nxm       = 1'b1;
          x_read_ack  = x_read;
          x_write_ack = ~x_read;
          state_d     = IDLE;
          last_d      = sel_b ? PORT_B : PORT_A;
        end else begin
          mem_read  = x_read;
          mem_write = x_write & ~x_read;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= PORT_B;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign a_read_ack  = x_read_ack  & ~sel_b;
  assign a_write_ack = x_write_ack & ~sel_b;
  assign a_nxm       = x_nxm       & ~sel_b;
  assign a_read_data = sel_b ? '0 : x_read_data;
  assign b_read_ack  = x_read_ack  & sel_b;
  assign b_write_ack = x_write_ack & sel_b;
  assign b_nxm       = x_nxm       & sel_b;
  assign b_read_data = sel_b ? x_read_data : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level arbitration model.
module tb_mem_arb;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 36;
  localparam int TB_TIMEOUT = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic          a_read, a_write, b_read, b_write;
  logic [DW-1:0] a_write_data, b_write_data, a_read_data, b_read_data;
  logic          a_read_ack, a_write_ack, a_nxm, b_read_ack, b_write_ack, b_nxm;
  logic          mem_read, mem_write, mem_read_ack, mem_write_ack;
  logic [DW-1:0] mem_write_data, mem_read_data;

  int checks = 0;
  int failures = 0;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_read(a_read), .a_write(a_write), .a_write_data(a_write_data),
    .a_read_data(a_read_data), .a_read_ack(a_read_ack), .a_write_ack(a_write_ack), .a_nxm(a_nxm),
    .b_addr(b_addr), .b_read(b_read), .b_write(b_write), .b_write_data(b_write_data),
    .b_read_data(b_read_data), .b_read_ack(b_read_ack), .b_write_ack(b_write_ack), .b_nxm(b_nxm),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: owner 0=none 1=A 2=B, last served port, busy-cycle count in current grant.
  int m_owner = 0;
  int m_last  = 2;
  int m_cnt   = 0;
  bit s_areq, s_breq, s_done, s_done_a, s_done_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = 0;
      m_last  = 2;
      m_cnt   = 0;
    end else if (m_owner == 0) begin
      if (s_areq && s_breq) m_owner = (m_last == 1) ? 2 : 1;
      else if (s_areq)      m_owner = 1;
      else if (s_breq)      m_owner = 2;
      m_cnt = 1;
    end else if (s_done) begin
      m_last  = m_owner;
      m_owner = 0;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : cmp
    logic rd, wr, anyack, tmo, e_mr, e_mw, e_ra, e_wa, is_a, is_b;
    logic [DW-1:0] e_rd;
    rd = 1'b0; wr = 1'b0; tmo = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
    e_ra = 1'b0; e_wa = 1'b0; e_rd = '0;
    anyack = mem_read_ack | mem_write_ack;
    is_a = !reset && (m_owner == 1);
    is_b = !reset && (m_owner == 2);
    if (is_a || is_b) begin
      rd   = is_a ? a_read  : b_read;
      wr   = is_a ? a_write : b_write;
      tmo  = TO_EN && (m_cnt >= TB_TIMEOUT) && !anyack;
      e_mr = rd && !tmo;
      e_mw = wr && !rd && !tmo;
      e_ra = mem_read_ack || (tmo && rd);
      e_wa = mem_write_ack || (tmo && !rd);
      e_rd = mem_read_ack ? mem_read_data : '0;
    end
    chk("mem_read", 64'(mem_read), 64'(e_mr));
    chk("mem_write", 64'(mem_write), 64'(e_mw));
    chk("a_read_ack", 64'(a_read_ack), 64'(is_a && e_ra));
    chk("a_write_ack", 64'(a_write_ack), 64'(is_a && e_wa));
    chk("a_nxm", 64'(a_nxm), 64'(is_a && tmo));
    chk("a_read_data", 64'(a_read_data), 64'(is_a ? e_rd : '0));
    chk("b_read_ack", 64'(b_read_ack), 64'(is_b && e_ra));
    chk("b_write_ack", 64'(b_write_ack), 64'(is_b && e_wa));
    chk("b_nxm", 64'(b_nxm), 64'(is_b && tmo));
    chk("b_read_data", 64'(b_read_data), 64'(is_b ? e_rd : '0));
    if (is_a || is_b) begin
      chk("mem_addr", 64'(mem_addr), 64'(is_a ? a_addr : b_addr));
      chk("mem_write_data", 64'(mem_write_data), 64'(is_a ? a_write_data : b_write_data));
    end
    s_areq   = !reset && (a_read || a_write);
    s_breq   = !reset && (b_read || b_write);
    s_done   = (is_a || is_b) && (anyack || tmo);
    s_done_a = s_done && is_a;
    s_done_b = s_done && is_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Random requester state, index 0 = A, 1 = B.
  bit            r_act [2];
  int            r_gap [2];
  bit            r_rd  [2];
  bit            r_wr  [2];
  logic [AW-1:0] r_ad  [2];
  logic [DW-1:0] r_wd  [2];
  int            lat;

  task automatic drive_random();
    int op;
    for (int p = 0; p < 2; p++) begin
      if ((p == 0) ? s_done_a : s_done_b) begin
        r_act[p] = 1'b0;
        r_gap[p] = $urandom_range(0, 3);
      end
      if (!r_act[p]) begin
        if (r_gap[p] == 0) begin
          op       = $urandom_range(0, 7);
          r_act[p] = 1'b1;
          r_rd[p]  = (op <= 3) || (op == 7);
          r_wr[p]  = (op >= 4);
          r_ad[p]  = AW'($urandom());
          r_wd[p]  = DW'({$urandom(), $urandom()});
        end else begin
          r_gap[p]--;
        end
      end
    end
    a_read = r_act[0] & r_rd[0];  a_write = r_act[0] & r_wr[0];
    a_addr = r_ad[0];             a_write_data = r_wd[0];
    b_read = r_act[1] & r_rd[1];  b_write = r_act[1] & r_wr[1];
    b_addr = r_ad[1];             b_write_data = r_wd[1];
    mem_read_data = DW'({$urandom(), $urandom()});
    mem_read_ack  = 1'b0;
    mem_write_ack = 1'b0;
    if (m_owner != 0) begin
      if (m_cnt == 1) lat = (TO_EN && ($urandom_range(0, 4) == 0)) ? 100 : $urandom_range(1, 4);
      if (m_cnt == lat) begin
        if (r_rd[m_owner-1]) mem_read_ack = 1'b1;
        else                 mem_write_ack = 1'b1;
      end
    end else if ($urandom_range(0, 5) == 0) begin
      if ($urandom_range(0, 1) == 0) mem_read_ack = 1'b1;
      else                           mem_write_ack = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    a_addr = '0; a_read = 1'b0; a_write = 1'b0; a_write_data = '0;
    b_addr = '0; b_read = 1'b0; b_write = 1'b0; b_write_data = '0;
    mem_read_data = '0; mem_read_ack = 1'b0; mem_write_ack = 1'b0;
    lat = 0;

    // Reset state.
    settle(); settle();
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_a_read_ack", 64'(a_read_ack), 64'd0);
    tick(); reset = 1'b0;
    settle();

    // Lone A read at 0o1000, mem acks 3 cycles after the strobe.
    tick(); a_addr = 22'o1000; a_read = 1'b1;
    settle(); chk("d2_idle_strobe", 64'(mem_read), 64'd0);
    tick(); settle();
    chk("d2_mem_read", 64'(mem_read), 64'd1);
    chk("d2_mem_addr", 64'(mem_addr), 64'o1000);
    tick(); settle();
    tick(); settle();
    tick(); mem_read_ack = 1'b1; mem_read_data = 36'o123456701234;
    settle();
    chk("d2_a_read_ack", 64'(a_read_ack), 64'd1);
    chk("d2_a_read_data", 64'(a_read_data), 64'o123456701234);
    chk("d2_b_read_ack", 64'(b_read_ack), 64'd0);
    chk("d2_b_write_ack", 64'(b_write_ack), 64'd0);
    tick(); mem_read_ack = 1'b0; mem_read_data = '0; a_read = 1'b0;
    settle(); chk("d2_after_mem_read", 64'(mem_read), 64'd0);

    // Reset mid BUSY_B write drops the strobe without a clock edge.
    tick(); b_addr = 22'o300; b_write_data = 36'o123456; b_write = 1'b1;
    settle();
    tick(); settle();
    chk("d5_mem_write", 64'(mem_write), 64'd1);
    #1 reset = 1'b1;
    #1 chk("d5_async_drop", 64'(mem_write), 64'd0);

    // After reset, A read 0o200 and B write 0o300 arrive together: A first.
    tick(); reset = 1'b0; a_addr = 22'o200; a_read = 1'b1;
    settle();
    tick(); settle();
    chk("d3_a_first_addr", 64'(mem_addr), 64'o200);
    chk("d3_a_first_read", 64'(mem_read), 64'd1);
    tick(); mem_read_ack = 1'b1; mem_read_data = 36'o7070;
    settle();
    chk("d3_a_read_ack", 64'(a_read_ack), 64'd1);
    chk("d3_b_ack_quiet", 64'(b_write_ack), 64'd0);
    tick(); mem_read_ack = 1'b0; a_read = 1'b0;
    settle(); chk("d3_idle_gap", 64'(mem_write), 64'd0);
    tick(); settle();
    chk("d3_b_write", 64'(mem_write), 64'd1);
    chk("d3_b_addr", 64'(mem_addr), 64'o300);
    chk("d3_b_wdata", 64'(mem_write_data), 64'o123456);
    tick(); mem_write_ack = 1'b1;
    settle();
    chk("d3_b_write_ack", 64'(b_write_ack), 64'd1);
    chk("d3_a_write_ack", 64'(a_write_ack), 64'd0);
    tick(); mem_write_ack = 1'b0; b_write = 1'b0;
    settle(); chk("d3_b_ack_once", 64'(b_write_ack), 64'd0);

    // Both ports hold reads: grants alternate A,B,A,B with one IDLE between.
    tick(); a_addr = 22'o10; a_read = 1'b1; b_addr = 22'o20; b_read = 1'b1;
    settle();
    for (int i = 1; i <= 8; i++) begin
      tick();
      mem_read_ack = (i % 2 == 1);
      if (i == 8) begin a_read = 1'b0; b_read = 1'b0; end
      settle();
      chk("d4_strobe", 64'(mem_read), 64'(i % 2 == 1));
      if (i % 2 == 1) chk("d4_grant_addr", 64'(mem_addr), (i % 4 == 1) ? 64'o10 : 64'o20);
    end
    tick(); mem_read_ack = 1'b0;
    settle();

    // A read with a silent mem.
    tick(); a_addr = 22'o500; a_read = 1'b1; mem_read_data = 36'o777;
    settle();
    for (int i = 1; i <= 8; i++) begin
      tick(); settle();
`ifdef MEM_ARB_TIMEOUT_EN
      chk("d6_a_read_ack", 64'(a_read_ack), 64'(i == 8));
      chk("d6_a_nxm", 64'(a_nxm), 64'(i == 8));
      chk("d6_mem_read", 64'(mem_read), 64'(i != 8));
`else
      chk("d6_a_read_ack", 64'(a_read_ack), 64'd0);
      chk("d6_mem_read", 64'(mem_read), 64'd1);
`endif
    end
`ifdef MEM_ARB_TIMEOUT_EN
    chk("d6_a_read_data", 64'(a_read_data), 64'd0);
    tick(); a_read = 1'b0;
    settle(); chk("d6_idle_after_nxm", 64'(mem_read), 64'd0);
`else
    repeat (4) begin
      tick(); settle();
      chk("d6_still_busy", 64'(mem_read), 64'd1);
    end
    tick(); mem_read_ack = 1'b1;
    settle(); chk("d6_late_ack", 64'(a_read_ack), 64'd1);
    tick(); mem_read_ack = 1'b0; a_read = 1'b0;
    settle();
`endif

    // A read+write together: read wins.
    tick(); a_addr = 22'o400; a_read = 1'b1; a_write = 1'b1; a_write_data = 36'o55;
    settle();
    tick(); settle();
    chk("d7_mem_read", 64'(mem_read), 64'd1);
    chk("d7_mem_write", 64'(mem_write), 64'd0);
    tick(); mem_read_ack = 1'b1; mem_read_data = 36'o4242;
    settle();
    chk("d7_a_read_ack", 64'(a_read_ack), 64'd1);
    chk("d7_a_write_ack", 64'(a_write_ack), 64'd0);
    chk("d7_a_read_data", 64'(a_read_data), 64'o4242);
    tick(); mem_read_ack = 1'b0; a_read = 1'b0; a_write = 1'b0;
    settle();

    // Randomized traffic.
    for (int p = 0; p < 2; p++) begin
      r_act[p] = 1'b0;
      r_gap[p] = $urandom_range(0, 3);
    end
    repeat (3000) begin
      tick(); drive_random(); settle();
    end

    tick();
    a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
    mem_read_ack = 1'b0; mem_write_ack = 1'b0;
    settle();
    repeat (3) begin tick(); settle(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
